// File: rtl/pcie_dma_pkg.sv
// pcie_dma_pkg: shared constants, TLP helpers and state encoding for the
// PCIe upstream DMA write engine (pcie_dma_writer, pcie_dma_fifo).
package pcie_dma_pkg;

    // BAR register indices
    localparam logic [3:0] REG_DMABASE = 4'd0;
    localparam logic [3:0] REG_DMACTRL = 4'd1;

    // Memory Write, 3DW header with data
    localparam logic [2:0] MWR_FMT  = 3'b010;
    localparam logic [4:0] MWR_TYPE = 5'b00000;

    // Payload per data TLP: 32 DW = 16 QW
    localparam logic [9:0] PAYLOAD_DW = 10'd32;
    localparam int         TLP_QWS    = 16;

    // Completion token MWr: 2 DW carrying a fixed signature
    localparam logic [9:0]  TOKEN_DW    = 10'd2;
    localparam logic [63:0] TOKEN_VALUE = 64'hCAFEF00DC0DEFACE;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        TOK0 = 3'd4,
        TOK1 = 3'd5,
        TOKD = 3'd6,
        DONE = 3'd7
    } dma_state_e;

    // Header DW0 for an MWr: TC/attr/EP/TD all zero, only length varies.
    function automatic logic [31:0] mwrDw0(input logic [9:0] lenDw);
        return {MWR_FMT, MWR_TYPE, 14'd0, lenDw};
    endfunction

endpackage

// File: rtl/pcie_dma_fifo.sv
// pcie_dma_fifo: synchronous 64-bit payload FIFO, depth 2**LOG2.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset (flushes the FIFO)
//   push_i, data_i write side (ignored when full)
//   pop_i, data_o  read side, data_o is the current head (ignored when empty)
//   full_o, empty_o, level_o  exact occupancy status
module pcie_dma_fifo #(
    parameter int LOG2 = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [63:0]     data_i,
    input  logic            pop_i,
    output logic [63:0]     data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [LOG2:0]   level_o
);
    localparam int DEPTH = 1 << LOG2;

    logic [63:0]   mem_q [DEPTH];
    logic [LOG2:0] wrPtr_q;
    logic [LOG2:0] rdPtr_q;
    logic          doPush;
    logic          doPop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level_o = wrPtr_q - rdPtr_q;
    assign full_o  = (level_o == (LOG2 + 1)'(DEPTH));
    assign empty_o = (level_o == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign data_o  = mem_q[rdPtr_q[LOG2-1:0]];

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q[LOG2-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

endmodule

// File: rtl/pcie_dma_writer.sv
// pcie_dma_writer: upstream DMA write engine. Software sets DMABASE and writes
// DMACTRL = N; the block sends N 128-byte MWr TLPs to base+64+128k, then
// (optionally) a completion-token MWr to base, and pulses done_out.
// Build option: define PCIE_DMA_TOKEN_EN to send the completion token.
// Ports:
//   clk_in, rstn                    clock, async active-low reset
//   regWr*_in                       BAR register write (0 DMABASE, 1 DMACTRL)
//   regRd*_in / regRd*_out          BAR register read, 1-cycle latency
//   srcData_in/srcValid_in/srcReady_out  payload stream into the FIFO
//   txData/txValid/txSop/txEop_out, txReady_in  Avalon-ST TX, ready latency 0
//   busy_out, done_out              DMA in progress / completion pulse
module pcie_dma_writer
    import pcie_dma_pkg::*;
#(
    parameter logic [15:0] REQ_ID    = 16'h0108,
    parameter int          FIFO_LOG2 = 5
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic        regWrValid_in,
    input  logic [3:0]  regWrAddr_in,
    input  logic [31:0] regWrData_in,
    input  logic        regRdValid_in,
    input  logic [3:0]  regRdAddr_in,
    output logic [31:0] regRdData_out,
    output logic        regRdValid_out,
    input  logic [63:0] srcData_in,
    input  logic        srcValid_in,
    output logic        srcReady_out,
    output logic [63:0] txData_out,
    output logic        txValid_out,
    output logic        txSop_out,
    output logic        txEop_out,
    input  logic        txReady_in,
    output logic        busy_out,
    output logic        done_out
);
    dma_state_e state_q, state_d;

    logic [31:0] dmaBase_q;
    logic [31:0] tlpAddr_q;
    logic [7:0]  tlpLeft_q;
    logic [3:0]  beatCnt_q;
    logic        hdrGo_q;
    logic [31:0] doneCnt_q;
    logic [31:0] rdData_q;
    logic        rdValid_q;
    logic [31:0] rdMux;
`ifdef PCIE_DMA_TOKEN_EN
    logic [31:0] tokBase_q;
`endif

    logic [63:0]        fifoData;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               fifoPush;
    logic               fifoPop;
    logic [FIFO_LOG2:0] fifoLevel;
    logic               levelOk;
    logic               ctrlAccept;
    logic               lastBeat;
    logic [31:0]        hdrDw1;

    pcie_dma_fifo #(.LOG2(FIFO_LOG2)) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rstn),
        .push_i  (fifoPush),
        .data_i  (srcData_in),
        .pop_i   (fifoPop),
        .data_o  (fifoData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (fifoLevel)
    );

    // Ready is held low while in reset so that every output reads 0 then.
    assign srcReady_out = rstn & ~fifoFull;
    assign fifoPush     = srcValid_in & srcReady_out;
    assign levelOk      = (fifoLevel >= (FIFO_LOG2 + 1)'(TLP_QWS));
    assign lastBeat     = (beatCnt_q == 4'd15);
    assign hdrDw1       = {REQ_ID, 8'h00, 8'hFF};
    assign ctrlAccept   = regWrValid_in && (regWrAddr_in == REG_DMACTRL) &&
                          (regWrData_in[7:0] != 8'd0) && (state_q == IDLE);

    assign regRdData_out  = rdData_q;
    assign regRdValid_out = rdValid_q;

    // FSM outputs. A TLP only starts once a full payload is buffered, so DATA
    // can never underrun and valid stays high from SOP to EOP.
    always_comb begin
        state_d     = state_q;
        txValid_out = 1'b0;
        txSop_out   = 1'b0;
        txEop_out   = 1'b0;
        txData_out  = '0;
        fifoPop     = 1'b0;
        busy_out    = 1'b1;
        done_out    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_out = 1'b0;
                if (ctrlAccept) state_d = HDR0;
            end
            // hdrGo_q lags the level check by one cycle, which also keeps SOP
            // one cycle behind the rise of busy_out.
            HDR0: begin
                txValid_out = hdrGo_q;
                txSop_out   = hdrGo_q;
                txData_out  = {hdrDw1, mwrDw0(PAYLOAD_DW)};
                if (hdrGo_q && txReady_in) state_d = HDR1;
            end
            HDR1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, tlpAddr_q};
                if (txReady_in) state_d = DATA;
            end
            DATA: begin
                txValid_out = 1'b1;
                txEop_out   = lastBeat;
                txData_out  = fifoData;
                fifoPop     = txReady_in & ~fifoEmpty;
                if (txReady_in && lastBeat) begin
                    if (tlpLeft_q != 8'd1) begin
                        state_d = HDR0;
                    end else begin
`ifdef PCIE_DMA_TOKEN_EN
                        state_d = TOK0;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef PCIE_DMA_TOKEN_EN
            TOK0: begin
                txValid_out = 1'b1;
                txSop_out   = 1'b1;
                txData_out  = {hdrDw1, mwrDw0(TOKEN_DW)};
                if (txReady_in) state_d = TOK1;
            end
            TOK1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, tokBase_q};
                if (txReady_in) state_d = TOKD;
            end
            TOKD: begin
                txValid_out = 1'b1;
                txEop_out   = 1'b1;
                txData_out  = TOKEN_VALUE;
                if (txReady_in) state_d = DONE;
            end
`endif
            DONE: begin
                busy_out = 1'b0;
                done_out = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                busy_out = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_comb begin
        rdMux = '0;
        case (regRdAddr_in)
            REG_DMABASE: rdMux = dmaBase_q;
            REG_DMACTRL: rdMux = doneCnt_q;
            default:     rdMux = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            dmaBase_q <= '0;
            tlpAddr_q <= '0;
            tlpLeft_q <= '0;
            beatCnt_q <= '0;
            hdrGo_q   <= 1'b0;
            doneCnt_q <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
`ifdef PCIE_DMA_TOKEN_EN
            tokBase_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            // The FIFO cannot drain while in HDR0, so once set this holds.
            hdrGo_q <= (state_q == HDR0) && levelOk;
            if (regWrValid_in && (regWrAddr_in == REG_DMABASE)) begin
                dmaBase_q <= {regWrData_in[31:3], 3'b000};
            end
            if (ctrlAccept) begin
                tlpLeft_q <= regWrData_in[7:0];
                tlpAddr_q <= dmaBase_q + 32'd64;
                beatCnt_q <= '0;
`ifdef PCIE_DMA_TOKEN_EN
                tokBase_q <= dmaBase_q;
`endif
            end
            if (fifoPop) begin
                beatCnt_q <= beatCnt_q + 4'd1;
                if (lastBeat) begin
                    tlpLeft_q <= tlpLeft_q - 8'd1;
                    tlpAddr_q <= tlpAddr_q + 32'd128;
                end
            end
            if (state_q == DONE) begin
                doneCnt_q <= doneCnt_q + 32'd1;
            end
            rdValid_q <= regRdValid_in;
            rdData_q  <= regRdValid_in ? rdMux : 32'h0;
        end
    end

endmodule

// File: tb/tb_pcie_dma_writer.sv
// tb_pcie_dma_writer: self-checking bench for pcie_dma_writer.
// A register table is applied first, then directed DMA sequences and
// randomized DMAs whose TX beat stream is compared with a queue-based model.
module tb_pcie_dma_writer;

    localparam logic [15:0] REQ_ID = 16'h0108;
    localparam logic [1:0]  OP_WR = 2'd0;
    localparam logic [1:0]  OP_RD = 2'd1;
    localparam logic [1:0]  OP_BUSY = 2'd2;

    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    logic        regWrValid_in = 1'b0;
    logic [3:0]  regWrAddr_in = '0;
    logic [31:0] regWrData_in = '0;
    logic        regRdValid_in = 1'b0;
    logic [3:0]  regRdAddr_in = '0;
    logic [31:0] regRdData_out;
    logic        regRdValid_out;
    logic [63:0] srcData_in = '0;
    logic        srcValid_in = 1'b0;
    logic        srcReady_out;
    logic [63:0] txData_out;
    logic        txValid_out;
    logic        txSop_out;
    logic        txEop_out;
    logic        txReady_in = 1'b1;
    logic        busy_out;
    logic        done_out;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    beat_t       gotQ[$];
    beat_t       expQ[$];
    logic [63:0] srcModelQ[$];
    logic [63:0] singleQws[16];
    vec_t        table_q[$];
    int          nChecks = 0;
    int          nFails = 0;
    int          expCount = 0;
    bit          randReady = 1'b0;

    pcie_dma_writer #(.REQ_ID(REQ_ID), .FIFO_LOG2(5)) dut (
        .clk_in         (clk_in),
        .rstn           (rstn),
        .regWrValid_in  (regWrValid_in),
        .regWrAddr_in   (regWrAddr_in),
        .regWrData_in   (regWrData_in),
        .regRdValid_in  (regRdValid_in),
        .regRdAddr_in   (regRdAddr_in),
        .regRdData_out  (regRdData_out),
        .regRdValid_out (regRdValid_out),
        .srcData_in     (srcData_in),
        .srcValid_in    (srcValid_in),
        .srcReady_out   (srcReady_out),
        .txData_out     (txData_out),
        .txValid_out    (txValid_out),
        .txSop_out      (txSop_out),
        .txEop_out      (txEop_out),
        .txReady_in     (txReady_in),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 clk_in = ~clk_in;

    // TX ready: always high, or randomly stalling about a third of cycles
    always @(posedge clk_in) begin
        #1;
        txReady_in = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    function automatic void checkOutput(input string name, input logic [127:0] got,
                                        input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    // TX monitor: collects accepted beats, checks stall stability and gaps
    logic [63:0] prevData = '0;
    logic        prevSop = 1'b0;
    logic        prevEop = 1'b0;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    bit          inPkt = 1'b0;

    always @(negedge clk_in) begin
        if (!rstn) begin
            inPkt     = 1'b0;
            prevValid = 1'b0;
            prevReady = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checkOutput("stall_hold", {txValid_out, txSop_out, txEop_out, txData_out},
                            {1'b1, prevSop, prevEop, prevData});
            end
            if (inPkt) checkOutput("no_gap", txValid_out, 1'b1);
            if (txValid_out && txReady_in) begin
                gotQ.push_back('{txData_out, txSop_out, txEop_out});
                if (txSop_out || inPkt) inPkt = !txEop_out;
            end
            prevValid = txValid_out;
            prevReady = txReady_in;
            prevData  = txData_out;
            prevSop   = txSop_out;
            prevEop   = txEop_out;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic regWrite(input logic [3:0] a, input logic [31:0] d);
        regWrValid_in = 1'b1;
        regWrAddr_in  = a;
        regWrData_in  = d;
        tick();
        regWrValid_in = 1'b0;
    endtask

    task automatic regRead(input logic [3:0] a, input logic [31:0] exp, input string name);
        regRdValid_in = 1'b1;
        regRdAddr_in  = a;
        tick();
        regRdValid_in = 1'b0;
        checkOutput({name, "_valid"}, regRdValid_out, 1'b1);
        checkOutput(name, regRdData_out, exp);
    endtask

    task automatic sendQw(input logic [63:0] d);
        int waitCnt = 0;
        bit taken = 1'b0;
        srcValid_in = 1'b1;
        srcData_in  = d;
        while (!taken && waitCnt < 2000) begin
            @(negedge clk_in);
            taken = srcReady_out;
            tick();
            waitCnt++;
        end
        srcValid_in = 1'b0;
        if (taken) srcModelQ.push_back(d);
        else checkOutput("src_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk_in);
            seen = done_out;
            n++;
        end
        checkOutput("done_seen", seen, 1'b1);
        tick();
        expCount++;
        checkOutput("idle_after_done", busy_out, 1'b0);
    endtask

    // Reference: the beat stream a DMA of n TLPs from base must produce
    task automatic runCheck(input logic [31:0] base, input int n, input string name);
        logic [31:0] qwBase;
        logic [31:0] addr;
        logic [63:0] d;
        expQ.delete();
        qwBase = {base[31:3], 3'b000};
        for (int k = 0; k < n; k++) begin
            addr = qwBase + 32'd64 + 32'd128 * 32'(k);
            expQ.push_back('{{REQ_ID, 8'h00, 8'hFF, 32'h40000020}, 1'b1, 1'b0});
            expQ.push_back('{{32'h0, addr}, 1'b0, 1'b0});
            for (int j = 0; j < 16; j++) begin
                d = (srcModelQ.size() > 0) ? srcModelQ.pop_front() : 64'h0;
                expQ.push_back('{d, 1'b0, (j == 15)});
            end
        end
`ifdef PCIE_DMA_TOKEN_EN
        expQ.push_back('{{REQ_ID, 8'h00, 8'hFF, 32'h40000002}, 1'b1, 1'b0});
        expQ.push_back('{{32'h0, qwBase}, 1'b0, 1'b0});
        expQ.push_back('{64'hCAFEF00DC0DEFACE, 1'b0, 1'b1});
`endif
        checkOutput({name, "_beats"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s_beat%0d", name, i),
                        {gotQ[i].sop, gotQ[i].eop, gotQ[i].data},
                        {expQ[i].sop, expQ[i].eop, expQ[i].data});
        end
        gotQ.delete();
    endtask

    task automatic runDma(input logic [31:0] base, input int n, input bit rnd,
                          input bit useSingle, input string name);
        randReady = rnd;
        regWrite(4'd0, base);
        regWrite(4'd1, 32'(n));
        checkOutput({name, "_busy_rise"}, busy_out, 1'b1);
        checkOutput({name, "_no_early_sop"}, txSop_out, 1'b0);
        for (int i = 0; i < 16 * n; i++) begin
            sendQw(useSingle ? singleQws[i % 16] : {$urandom, $urandom});
        end
        waitDone(400 * n + 200);
        randReady = 1'b0;
        runCheck(base, n, name);
        regRead(4'd1, 32'(expCount), {name, "_counter"});
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        case (v.op)
            OP_WR:   regWrite(v.addr, v.data);
            OP_RD:   regRead(v.addr, v.exp, $sformatf("table%0d_rd", idx));
            default: checkOutput($sformatf("table%0d_busy", idx), busy_out, v.exp[0]);
        endcase
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        bit found;
        bit sawTx;

        singleQws[0]  = 64'hD94228FF25158B13;
        singleQws[15] = 64'h4106B168D88FE2A6;
        for (int i = 1; i < 15; i++) singleQws[i] = {$urandom, $urandom};

        // Reset state
        repeat (3) @(negedge clk_in);
        checkOutput("rst_txValid", txValid_out, 1'b0);
        checkOutput("rst_txSop", txSop_out, 1'b0);
        checkOutput("rst_txEop", txEop_out, 1'b0);
        checkOutput("rst_txData", txData_out, 64'h0);
        checkOutput("rst_busy", busy_out, 1'b0);
        checkOutput("rst_done", done_out, 1'b0);
        checkOutput("rst_srcReady", srcReady_out, 1'b0);
        checkOutput("rst_rdValid", regRdValid_out, 1'b0);
        checkOutput("rst_rdData", regRdData_out, 32'h0);
        @(posedge clk_in);
        #1 rstn = 1'b1;
        tick();
        checkOutput("post_rst_srcReady", srcReady_out, 1'b1);

        // Register table
        table_q.push_back('{OP_RD,   4'd1,  32'h0,        32'h0});
        table_q.push_back('{OP_RD,   4'd0,  32'h0,        32'h0});
        table_q.push_back('{OP_WR,   4'd0,  32'h12345677, 32'h0});
        table_q.push_back('{OP_RD,   4'd0,  32'h0,        32'h12345670});
        table_q.push_back('{OP_RD,   4'd2,  32'h0,        32'h0});
        table_q.push_back('{OP_RD,   4'd15, 32'h0,        32'h0});
        table_q.push_back('{OP_WR,   4'd1,  32'h00000100, 32'h0});
        table_q.push_back('{OP_BUSY, 4'd0,  32'h0,        32'h0});
        table_q.push_back('{OP_WR,   4'd0,  32'h00000020, 32'h0});
        table_q.push_back('{OP_RD,   4'd0,  32'h0,        32'h00000020});
        for (int i = 0; i < table_q.size(); i++) applyStimulus(table_q[i], i);

        // Single DMA, payload buffered before the control write
        randReady = 1'b0;
        for (int i = 0; i < 16; i++) sendQw(singleQws[i]);
        regWrite(4'd1, 32'd1);
        checkOutput("single_busy_rise", busy_out, 1'b1);
        waitDone(300);
        if (gotQ.size() >= 18) begin
            checkOutput("single_hdr0", gotQ[0].data, 64'h010800FF40000020);
            checkOutput("single_hdr1", gotQ[1].data, 64'h0000000000000060);
            checkOutput("single_first_qw", gotQ[2].data, 64'hD94228FF25158B13);
            checkOutput("single_last_qw", {gotQ[17].eop, gotQ[17].data},
                        {1'b1, 64'h4106B168D88FE2A6});
        end else begin
            checkOutput("single_size", gotQ.size(), 18);
        end
`ifdef PCIE_DMA_TOKEN_EN
        if (gotQ.size() >= 21) begin
            checkOutput("single_tok0", gotQ[18].data, 64'h010800FF40000002);
            checkOutput("single_tok1", gotQ[19].data, 64'h0000000000000020);
            checkOutput("single_tokd", gotQ[20].data, 64'hCAFEF00DC0DEFACE);
        end else begin
            checkOutput("single_tok_size", gotQ.size(), 21);
        end
`endif
        runCheck(32'h20, 1, "single");
        regRead(4'd1, 32'd1, "single_counter");

        // Multi-TLP: addresses 0x60, 0xE0, 0x160
        runDma(32'h20, 3, 1'b0, 1'b0, "multi");

        // Backpressure with the single-DMA payload
        runDma(32'h20, 1, 1'b1, 1'b1, "bp");

        // Starved source, plus a DMACTRL write while busy
        randReady = 1'b0;
        regWrite(4'd0, 32'h100);
        regWrite(4'd1, 32'd1);
        regWrite(4'd1, 32'd5);
        checkOutput("starve_busy", busy_out, 1'b1);
        for (int i = 0; i < 15; i++) sendQw({$urandom, $urandom});
        sawTx = 1'b0;
        repeat (20) begin
            @(negedge clk_in);
            if (txValid_out) sawTx = 1'b1;
        end
        checkOutput("starve_no_sop", sawTx, 1'b0);
        tick();
        sendQw({$urandom, $urandom});
        cycles = 0;
        found = 1'b0;
        while (!found && cycles < 10) begin
            @(negedge clk_in);
            cycles++;
            found = txValid_out && txSop_out;
        end
        checkOutput("starve_sop_within_2", (found && cycles <= 2), 1'b1);
        tick();
        waitDone(300);
        runCheck(32'h100, 1, "starve");
        regRead(4'd1, 32'(expCount), "starve_counter");

        // Randomized DMAs, first one wraps the 32-bit address
        for (int it = 0; it < 6; it++) begin
            runDma((it == 0) ? 32'hFFFFFFC4 : $urandom, $urandom_range(1, 4),
                   1'(($urandom_range(0, 1))), 1'b0, $sformatf("rand%0d", it));
        end

        // Reset pulse in the middle of DATA
        randReady = 1'b0;
        regWrite(4'd0, 32'h40);
        regWrite(4'd1, 32'd1);
        for (int i = 0; i < 16; i++) sendQw({$urandom, $urandom});
        cycles = 0;
        while (gotQ.size() < 5 && cycles < 200) begin
            tick();
            cycles++;
        end
        checkOutput("mid_reached_data", (gotQ.size() >= 5), 1'b1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_txValid", txValid_out, 1'b0);
        checkOutput("mid_rst_busy", busy_out, 1'b0);
        @(negedge clk_in);
        tick();
        rstn = 1'b1;
        tick();
        gotQ.delete();
        srcModelQ.delete();
        expCount = 0;
        regRead(4'd1, 32'h0, "mid_counter_cleared");
        regRead(4'd0, 32'h0, "mid_base_cleared");
        runDma(32'h40, 1, 1'b0, 1'b0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
